// File: rtl/nvt_sv_vmon_pkg.sv
// Shared types for the voltage monitor: sample classes, channel FSM states
// and the window classifier.
package nvt_sv_vmon_pkg;

    typedef enum logic [1:0] {
        CLS_OK = 2'd0,
        CLS_UV = 2'd1,
        CLS_OV = 2'd2
    } cls_t;

    typedef enum logic [1:0] {
        S_OK       = 2'd0,
        S_PEND_FLT = 2'd1,
        S_FAULT    = 2'd2,
        S_PEND_OK  = 2'd3
    } state_t;

    // Inclusive window; a NaN (undriven/unknown net) fails both compares and lands in UV.
    function automatic cls_t classify(input real v, input real lo, input real hi);
        if (v >= lo && v <= hi) return CLS_OK;
        else if (v > hi)        return CLS_OV;
        else                    return CLS_UV;
    endfunction

endpackage

// File: rtl/nvt_sv_vmon_ch.sv
// One monitored channel: debounce FSM with saturating counter, registered ok
// status and same-edge sticky-set requests towards the top.
module nvt_sv_vmon_ch
    import nvt_sv_vmon_pkg::*;
#(
    parameter int unsigned DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_sample,
    input  logic i_mask,
    input  cls_t i_cls,
    output logic o_ok,
    output logic o_set_uv,
    output logic o_set_ov
);

    localparam int unsigned CW = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t         r_state;
    cls_t           r_cls;
    logic [CW-1:0]  r_cnt;
    logic           r_ok;
    logic           w_bad;
    logic           w_act;
    logic [CW-1:0]  w_cnt_inc;
    cls_t           w_set_cls;

    assign w_bad     = (i_cls != CLS_OK);
    assign w_act     = i_en && i_sample && !i_mask;
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_set_cls = CLS_OK;
        if (w_act) begin
            case (r_state)
                S_OK:       if (w_bad && DEB_CYC == 1) w_set_cls = i_cls;
                S_PEND_FLT: if (w_bad && i_cls == r_cls && w_cnt_inc == CNT_MAX) w_set_cls = r_cls;
                S_FAULT:    if (w_bad) w_set_cls = i_cls;
                default:    w_set_cls = CLS_OK;
            endcase
        end
    end

    assign o_set_uv = (w_set_cls == CLS_UV);
    assign o_set_ov = (w_set_cls == CLS_OV);
    assign o_ok     = r_ok;

    always_ff @(posedge clk) begin
        if (rst || !i_en || i_mask) begin
            r_state <= S_OK;
            r_cls   <= CLS_OK;
            r_cnt   <= '0;
            r_ok    <= 1'b1;
        end else if (i_sample) begin
            case (r_state)
                S_OK: begin
                    if (w_bad) begin
                        r_cls <= i_cls;
                        if (DEB_CYC == 1) begin
                            r_state <= S_FAULT;
                            r_ok    <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_PEND_FLT;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end
                S_PEND_FLT: begin
                    if (!w_bad) begin
                        r_state <= S_OK;
                        r_cnt   <= '0;
                    end else if (i_cls != r_cls) begin
                        r_cls <= i_cls;
                        r_cnt <= CNT_ONE;
                    end else if (w_cnt_inc == CNT_MAX) begin
                        r_state <= S_FAULT;
                        r_ok    <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_FAULT: begin
                    if (!w_bad) begin
                        if (DEB_CYC == 1) begin
                            r_state <= S_OK;
                            r_ok    <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_PEND_OK;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end
                S_PEND_OK: begin
                    if (w_bad) begin
                        r_state <= S_FAULT;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc == CNT_MAX) begin
                        r_state <= S_OK;
                        r_ok    <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= S_OK;
                    r_cnt   <= '0;
                    r_ok    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/nvt_sv_vmon.sv
// Multi-channel voltage window monitor: round-robin scan pointer, window
// classifier, per-channel debounce FSMs, sticky UV/OV flags and irq pulse.
module nvt_sv_vmon
    import nvt_sv_vmon_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter real         exp_val [NUM_CH] = '{default: 1.0},
    parameter real         accuracy = 0.1,
    parameter int unsigned DEB_CYC  = 4,
    localparam int unsigned PW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  real               in [NUM_CH],
    input  logic [NUM_CH-1:0] mask,
    input  logic              clr,
    output logic [NUM_CH-1:0] ok,
    output logic [NUM_CH-1:0] uv,
    output logic [NUM_CH-1:0] ov,
    output logic              irq,
    output logic [PW-1:0]     ptr
);

    logic [PW-1:0]     r_ptr;
    logic [NUM_CH-1:0] r_uv;
    logic [NUM_CH-1:0] r_ov;
    logic              r_irq;
    logic [NUM_CH-1:0] w_set_uv;
    logic [NUM_CH-1:0] w_set_ov;
    logic [NUM_CH-1:0] w_uv_nxt;
    logic [NUM_CH-1:0] w_ov_nxt;
    real               w_exp;
    real               w_span;
    cls_t              w_cls;

    always_comb begin
        w_exp  = exp_val[r_ptr];
        w_span = ((w_exp < 0.0) ? -w_exp : w_exp) * accuracy;
        w_cls  = mask[r_ptr] ? CLS_OK : classify(in[r_ptr], w_exp - w_span, w_exp + w_span);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        nvt_sv_vmon_ch #(
            .DEB_CYC(DEB_CYC)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_en     (en),
            .i_sample (r_ptr == PW'(g)),
            .i_mask   (mask[g]),
            .i_cls    (w_cls),
            .o_ok     (ok[g]),
            .o_set_uv (w_set_uv[g]),
            .o_set_ov (w_set_ov[g])
        );
    end

    // Set wins over a same-edge clear; irq only on a genuine 0->1 of a sticky bit.
    assign w_uv_nxt = (clr ? '0 : r_uv) | w_set_uv;
    assign w_ov_nxt = (clr ? '0 : r_ov) | w_set_ov;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_uv  <= '0;
            r_ov  <= '0;
            r_irq <= 1'b0;
        end else begin
            r_uv  <= w_uv_nxt;
            r_ov  <= w_ov_nxt;
            r_irq <= en && (|((w_uv_nxt & ~r_uv) | (w_ov_nxt & ~r_ov)));
            if (!en || r_ptr == PW'(NUM_CH - 1)) r_ptr <= '0;
            else                                   r_ptr <= r_ptr + 1'b1;
        end
    end

    assign uv  = r_uv;
    assign ov  = r_ov;
    assign irq = r_irq;
    assign ptr = r_ptr;

endmodule

// File: tb/tb_nvt_sv_vmon.sv
// Directed bench for nvt_sv_vmon with NUM_CH=4, DEB_CYC=3, window [0.9,1.1].
module tb_nvt_sv_vmon;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    real        in_v [4];
    logic [3:0] mask;
    logic       clr;
    logic [3:0] ok;
    logic [3:0] uv;
    logic [3:0] ov;
    logic       irq;
    logic [1:0] ptr;

    int n_checks = 0;
    int n_fail   = 0;

    real HI = 1.0 + 1.0 * 0.1;
    real LO = 1.0 - 1.0 * 0.1;

    nvt_sv_vmon #(
        .NUM_CH   (4),
        .accuracy (0.1),
        .DEB_CYC  (3)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .in   (in_v),
        .mask (mask),
        .clr  (clr),
        .ok   (ok),
        .uv   (uv),
        .ov   (ov),
        .irq  (irq),
        .ptr  (ptr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After this returns, the next tick is edge 1 with ptr=0 sampling ch0.
    task automatic do_reset();
        rst  = 1'b1;
        en   = 1'b1;
        clr  = 1'b0;
        mask = 4'b0000;
        for (int i = 0; i < 4; i++) in_v[i] = 1.0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({irq, uv, ov, ok, ptr} !== {1'b0, 4'b0000, 4'b0000, 4'b1111, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got irq=%b uv=%b ov=%b ok=%b ptr=%0d, want 0/0000/0000/1111/0",
                     irq, uv, ov, ok, ptr);
        end
    endtask

    task automatic test_uv_detect();
        logic [14:0] exp_v;
        do_reset();
        in_v[1] = 0.85;
        for (int n = 1; n <= 12; n++) begin
            tick();
            exp_v = {(n == 10), {2'b00, (n >= 10), 1'b0}, 4'b0000, {2'b11, (n < 10), 1'b1}, 2'(n % 4)};
            n_checks++;
            if ({irq, uv, ov, ok, ptr} !== exp_v) begin
                n_fail++;
                $display("FAIL uv_detect edge %0d: got {irq,uv,ov,ok,ptr}=%b want %b", n, {irq, uv, ov, ok, ptr}, exp_v);
            end
        end
    endtask

    task automatic test_disable();
        en = 1'b0;
        tick();
        n_checks++;
        if ({irq, uv, ov, ok, ptr} !== {1'b0, 4'b0010, 4'b0000, 4'b1111, 2'd0}) begin
            n_fail++;
            $display("FAIL disable: got {irq,uv,ov,ok,ptr}=%b want %b",
                     {irq, uv, ov, ok, ptr}, {1'b0, 4'b0010, 4'b0000, 4'b1111, 2'd0});
        end
        tick();
        n_checks++;
        if (ptr !== 2'd0 || ok !== 4'b1111 || uv !== 4'b0010) begin
            n_fail++;
            $display("FAIL disable_hold: got ptr=%0d ok=%b uv=%b want 0/1111/0010", ptr, ok, uv);
        end
        en = 1'b1;
    endtask

    task automatic test_glitch();
        do_reset();
        in_v[2] = 1.2;
        for (int n = 1; n <= 16; n++) begin
            if (n == 8) in_v[2] = 1.0;
            tick();
            n_checks++;
            if ({irq, ov, ok} !== {1'b0, 4'b0000, 4'b1111}) begin
                n_fail++;
                $display("FAIL glitch edge %0d: got irq=%b ov=%b ok=%b want 0/0000/1111", n, irq, ov, ok);
            end
        end
    endtask

    task automatic test_boundary();
        logic [12:0] exp_v;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            in_v[0] = (((n - 1) / 4) % 2 == 1) ? LO : HI;
            tick();
            n_checks++;
            if ({irq, uv, ov, ok} !== {1'b0, 4'b0000, 4'b0000, 4'b1111}) begin
                n_fail++;
                $display("FAIL boundary edge %0d: got irq=%b uv=%b ov=%b ok=%b want 0/0000/0000/1111",
                         n, irq, uv, ov, ok);
            end
        end
        in_v[0] = 1.1001;
        for (int n = 41; n <= 52; n++) begin
            tick();
            exp_v = {(n == 49), 4'b0000, {3'b000, (n >= 49)}, {3'b111, (n < 49)}};
            n_checks++;
            if ({irq, uv, ov, ok} !== exp_v) begin
                n_fail++;
                $display("FAIL just_over edge %0d: got {irq,uv,ov,ok}=%b want %b", n, {irq, uv, ov, ok}, exp_v);
            end
        end
    endtask

    task automatic test_clr_same_edge();
        logic [4:0] exp_v;
        do_reset();
        in_v[3] = 0.0;
        for (int n = 1; n <= 22; n++) begin
            if (n == 13) in_v[0] = 0.5;
            if (n == 21) begin
                clr     = 1'b1;
                in_v[3] = 1.0;
            end
            if (n == 22) clr = 1'b0;
            tick();
            if (n < 12)       exp_v = {1'b0, 4'b0000};
            else if (n < 21)  exp_v = {(n == 12), 4'b1000};
            else              exp_v = {(n == 21), 4'b0001};
            n_checks++;
            if ({irq, uv} !== exp_v) begin
                n_fail++;
                $display("FAIL clr_same_edge edge %0d: got {irq,uv}=%b want %b", n, {irq, uv}, exp_v);
            end
        end
    endtask

    task automatic test_mask();
        logic [4:0] exp_v;
        do_reset();
        mask    = 4'b1000;
        in_v[3] = 0.0;
        for (int n = 1; n <= 30; n++) begin
            if (n == 17) mask = 4'b0000;
            tick();
            exp_v = {(n == 28), (n >= 28), (n < 28), irq === 1'b1 ? 2'b00 : 2'b00};
            n_checks++;
            if ({irq, uv[3], ok[3], 2'b00} !== exp_v) begin
                n_fail++;
                $display("FAIL mask edge %0d: got irq=%b uv3=%b ok3=%b want irq=%b uv3=%b ok3=%b",
                         n, irq, uv[3], ok[3], exp_v[4], exp_v[3], exp_v[2]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_v[1] = 0.85;
        for (int n = 1; n <= 6; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({irq, uv, ov, ok, ptr} !== {1'b0, 4'b0000, 4'b0000, 4'b1111, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_mid: got {irq,uv,ov,ok,ptr}=%b want %b",
                     {irq, uv, ov, ok, ptr}, {1'b0, 4'b0000, 4'b0000, 4'b1111, 2'd0});
        end
        for (int n = 1; n <= 11; n++) begin
            tick();
            n_checks++;
            if ({irq, uv[1], ok[1]} !== {(n == 10), (n >= 10), (n < 10)}) begin
                n_fail++;
                $display("FAIL reset_refault edge %0d: got irq=%b uv1=%b ok1=%b want %b/%b/%b",
                         n, irq, uv[1], ok[1], (n == 10), (n >= 10), (n < 10));
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        clr  = 1'b0;
        mask = 4'b0000;
        for (int i = 0; i < 4; i++) in_v[i] = 1.0;
        test_reset();
        test_uv_detect();
        test_disable();
        test_glitch();
        test_boundary();
        test_clr_same_edge();
        test_mask();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nvt_sv_vmon.md
NVT_SV_VMON -- requirements
Module: nvt_sv_vmon

Interface
REQ-001 Parameter NUM_CH, 4, number of monitored real-valued channels (1..16).
REQ-002 Parameter exp_val, real array [NUM_CH] all 1.0, per-channel expected voltage.
REQ-003 Parameter accuracy, 0.1, relative window half-width; window = exp_val +/- |exp_val|*accuracy, bounds inclusive.
REQ-004 Parameter DEB_CYC, 4, consecutive same-class samples needed to change debounced state (1..255).
REQ-005 clk  input  1  system clock; reset is synchronous and active-high.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 en  input  1  monitor enable.
REQ-008 in  input  `REAL_NET [NUM_CH]  monitored voltages.
REQ-009 mask  input  NUM_CH  1 = channel ignored.
REQ-010 clr  input  1  one-cycle request to clear sticky flags.
REQ-011 ok  output  NUM_CH  debounced in-window status per channel.
REQ-012 uv / ov  output  NUM_CH each  sticky under-/over-voltage flags.
REQ-013 irq  output  1  one-cycle pulse when any sticky bit goes 0->1.
REQ-014 ptr  output  $clog2(NUM_CH) (min 1)  index of channel sampled this cycle.

Function
REQ-015 Scan: with en=1, ptr advances by one per clk, wrapping NUM_CH-1 -> 0; channel ptr is sampled each cycle, so each channel is sampled every NUM_CH cycles.
REQ-016 Classification of sampled value: OK if exp_min <= in <= exp_max; UV if below; OV if above; `wrealZState or `wrealXState classifies as UV.
REQ-017 Masked channel classifies as OK regardless of input; its FSM is held in S_OK and ok bit reads 1.
REQ-018 Per-channel FSM states S_OK, S_PEND_FLT, S_FAULT, S_PEND_OK; counter width $clog2(DEB_CYC+1), saturating at DEB_CYC.
REQ-019 S_OK: bad sample -> S_PEND_FLT, cnt=1, latch class; good sample -> stay.
REQ-020 S_PEND_FLT: same-class bad sample increments cnt; other bad class restarts cnt=1 with new class; good sample -> S_OK, cnt=0; cnt reaching DEB_CYC -> S_FAULT, sets ok=0 and sticky uv or ov per latched class.
REQ-021 S_FAULT: good sample -> S_PEND_OK, cnt=1; bad sample stays, sets the sticky bit of its class.
REQ-022 S_PEND_OK: good sample increments; cnt reaching DEB_CYC -> S_OK, ok=1; bad sample -> S_FAULT, cnt=0.
REQ-023 DEB_CYC=1: transition on the first qualifying sample, no pending states entered.
REQ-024 Outputs registered; ok/uv/ov update on the clk edge that samples the deciding value; irq asserts the same edge.
REQ-025 Worst-case detection latency from a persistent fault = NUM_CH*DEB_CYC cycles.
REQ-026 clr clears all uv/ov bits on the next edge; a bit set on that same edge stays 1 (set wins) and irq pulses.
REQ-027 en=0: ptr forced 0, all FSMs to S_OK, counters 0, ok all 1, irq 0; uv/ov retained.
REQ-028 Channels are sampled only when ptr selects them; state of non-selected channels is unchanged.

Reset
REQ-029 rst=1 at clk edge: ptr=0, all FSMs S_OK, counters 0, ok all 1, uv=0, ov=0, irq=0; rst overrides en and clr.
REQ-030 rst mid-pending discards partial counts; no irq on reset exit.

Structure
REQ-031 Package nvt_sv_vmon_pkg holds the class enum (CLS_OK, CLS_UV, CLS_OV) and the FSM state enum.
REQ-032 Sub-module nvt_sv_vmon_ch implements one channel's FSM and counter, instantiated NUM_CH times by generate; top holds scan pointer, classifier, sticky flags, irq.

Verification (NUM_CH=4, DEB_CYC=3, exp_val=1.0, accuracy=0.1, window [0.9,1.1])
REQ-033 ch1 held at 0.85 from cycle 0 -> uv[1]=1, ok[1]=0 and a one-cycle irq on the third sample of ch1 (cycle 9 if ptr=1 at cycle 1).
REQ-034 ch2 at 1.2 for two samples then 1.0 -> no ov, ok[2] stays 1, no irq.
REQ-035 ch0 at exactly 1.1 and 0.9 for 10 scans -> no flags; 1.1001 for 3 samples -> ov[0]=1.
REQ-036 clr pulsed on the edge ch0 completes a UV fault while uv[3]=1 -> uv[3]=0, uv[0]=1, irq pulses.
REQ-037 mask[3]=1, in[3]=0.0 -> ok[3]=1, uv[3]=0; unmask -> uv[3] sets after 3 samples.
REQ-038 rst during S_PEND_FLT of ch1 (cnt=2) -> all outputs at reset values next edge; fault needs 3 fresh samples after release.
